// File: rtl/uart_pkg.sv
// Shared UART types used by the transmit queue and its neighbours.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN
  } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer/transmitter side signals of uart_tx_queue; flush exists only with UART_TXQ_FLUSH_EN.
interface uart_tx_queue_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic [WIDTH-1:0] tx_din;
  logic             tx_send;
  logic             tx_busy;
`ifdef UART_TXQ_FLUSH_EN
  logic             flush;

  modport slave (
    input  wr_en, wr_data, tx_busy, flush,
    output full, empty, count, overflow, tx_din, tx_send
  );
  modport master (
    output wr_en, wr_data, tx_busy, flush,
    input  full, empty, count, overflow, tx_din, tx_send
  );
`else
  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, count, overflow, tx_din, tx_send
  );
  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, count, overflow, tx_din, tx_send
  );
`endif
endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Power-of-two circular FIFO with sticky overflow; flush port only with UART_TXQ_FLUSH_EN.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef UART_TXQ_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             flush_w;

`ifdef UART_TXQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign overflow = overflow_q;
  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  always_comb begin
    push_ok    = wr_en && (!full || pop) && !flush_w;
    wr_ptr_d   = wr_ptr_q + PW'(push_ok);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    overflow_d = overflow_q | (wr_en && full && !pop);
    if (flush_w) begin
      rd_ptr_d   = wr_ptr_q;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter din/send/busy handshake; UART_TXQ_FLUSH_EN adds flush.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_queue_if.slave    bus
);
  txq_state_t             state_q, state_d;
  logic [WIDTH-1:0]       tx_din_q, tx_din_d;
  logic [WIDTH-1:0]       head;
  logic                   fifo_empty;
  logic                   pop;
  logic                   flush_w;
  logic                   tx_send;

`ifdef UART_TXQ_FLUSH_EN
  assign flush_w = bus.flush;
`else
  assign flush_w = 1'b0;
`endif

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
`ifdef UART_TXQ_FLUSH_EN
    .flush    (bus.flush),
`endif
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .pop      (pop),
    .rd_data  (head),
    .full     (bus.full),
    .empty    (fifo_empty),
    .count    (bus.count),
    .overflow (bus.overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tx_din_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_din_q <= tx_din_d;
    end
  end

  // Busy seen in IDLE belongs to another sender: hold off until it clears.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop)         state_d = SEND;
      SEND:    if (bus.tx_busy) state_d = DRAIN;
      DRAIN:   if (!bus.tx_busy) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = (state_q == IDLE) && !fifo_empty && !bus.tx_busy && !flush_w;
    tx_send  = (state_q == SEND);
    tx_din_d = pop ? head : tx_din_q;
  end

  assign bus.empty   = fifo_empty;
  assign bus.tx_send = tx_send;
  assign bus.tx_din  = tx_din_q;

endmodule
